// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential requests, holds returns in an in-order prefetch queue.
// Define FETCH_PERF_EN to add saturating perf_fetched / perf_dropped counters.
module fetch_unit #(
    parameter int                  DEPTH    = 4,
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [PC_WIDTH-1:0] imem_req_addr,
    input  logic                imem_resp_valid,
    input  logic [31:0]         imem_resp_data,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                if_valid,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic [31:0]         if_instruction
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_dropped
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

    // Slots between head and fill are filled, between fill and tail are waiting on memory.
    logic [CNT_W-1:0]    head_q, head_d, fill_q, fill_d, tail_q, tail_d;
    logic [CNT_W-1:0]    disc_q, disc_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] pc_q [DEPTH];
    logic [PC_WIDTH-1:0] pc_d [DEPTH];
    logic [31:0]         instr_q [DEPTH];
    logic [31:0]         instr_d [DEPTH];

    logic [CNT_W-1:0] count, filled_cnt, unfilled;
    logic [CNT_W:0]   occ_total;
    logic             accept, deq, drop;

    always_comb begin
        count      = tail_q - head_q;
        filled_cnt = fill_q - head_q;
        unfilled   = tail_q - fill_q;
        occ_total  = {1'b0, count} + {1'b0, disc_q};

        imem_req_valid = !reset && !redirect && (occ_total < DEPTH_W);
        imem_req_addr  = fetch_pc_q;
        accept         = imem_req_valid && imem_req_ready;

        if_valid       = (filled_cnt != '0) && !redirect;
        if_pc          = pc_q[head_q[PTR_W-1:0]];
        if_instruction = instr_q[head_q[PTR_W-1:0]];
        deq            = if_valid && !stall;
        drop           = imem_resp_valid && (redirect || (disc_q != '0));

        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        fill_d     = fill_q;
        tail_d     = tail_q;
        disc_d     = disc_q;
        pc_d       = pc_q;
        instr_d    = instr_q;

        if (redirect) begin
            // Every outstanding unfilled slot still owes a response that must be thrown away.
            fetch_pc_d = redirect_pc;
            head_d     = tail_q;
            fill_d     = tail_q;
            disc_d     = disc_q + unfilled - CNT_W'(imem_resp_valid);
        end else begin
            if (accept) begin
                pc_d[tail_q[PTR_W-1:0]] = fetch_pc_q;
                tail_d                  = tail_q + 1'b1;
                fetch_pc_d              = fetch_pc_q + PC_WIDTH'(4);
            end
            if (imem_resp_valid) begin
                if (disc_q != '0) begin
                    disc_d = disc_q - 1'b1;
                end else begin
                    instr_d[fill_q[PTR_W-1:0]] = imem_resp_data;
                    fill_d                     = fill_q + 1'b1;
                end
            end
            if (deq) begin
                head_d = head_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            fill_q     <= '0;
            tail_q     <= '0;
            disc_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            fill_q     <= fill_d;
            tail_q     <= tail_d;
            disc_q     <= disc_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_dropped_q, perf_dropped_d;
    logic [32:0] drop_sum;

    // Redirect clears filled slots unseen by decode; they count alongside dropped responses.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        if (deq && (perf_fetched_q != '1)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        drop_sum       = {1'b0, perf_dropped_q} + 33'(drop)
                         + (redirect ? 33'(filled_cnt) : 33'd0);
        perf_dropped_d = drop_sum[32] ? '1 : drop_sum[31:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_dropped_q <= perf_dropped_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order variable-latency memory plus a queue-level reference model.
module tb_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam int          PW       = 64;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic [PW-1:0] imem_req_addr;
    logic          imem_resp_valid = 1'b0;
    logic [31:0]   imem_resp_data = '0;
    logic          stall = 1'b0;
    logic          redirect = 1'b0;
    logic [PW-1:0] redirect_pc = '0;
    logic          if_valid;
    logic [PW-1:0] if_pc;
    logic [31:0]   if_instruction;
`ifdef FETCH_PERF_EN
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_dropped;
`endif

    fetch_unit #(.DEPTH(DEPTH), .PC_WIDTH(PW), .RESET_PC(RESET_PC)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instruction (if_instruction)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        bit          filled;
    } ent_t;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;

    ent_t        mq[$];
    pend_t       pend[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_due = -1;
    int          lat_lo = 1, lat_hi = 1;
    bit          rdy = 1'b0, stl = 1'b0, rdr = 1'b0, arm_resp = 1'b0, fired = 1'b0;
    logic [63:0] rpc = '0;
    logic [63:0] m_fetch_pc, next_pc;
    int          m_disc = 0;
    int          m_fetched = 0, m_dropped = 0;
    int          since_reset = 0, first_iv = -1, acc_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset           = 1'b1;
        imem_resp_valid = 1'b0;
        redirect        = 1'b0;
        #1;
        check("rst_if_valid", if_valid, 64'd0);
        check("rst_req_valid", imem_req_valid, 64'd0);
        pend.delete();
        mq.delete();
        m_disc      = 0;
        m_fetch_pc  = RESET_PC;
        next_pc     = RESET_PC;
        m_fetched   = 0;
        m_dropped   = 0;
        last_due    = -1;
        since_reset = 0;
        first_iv    = -1;
        repeat (2) @(posedge clock);
    endtask

    // One clock: drive at negedge, check combinational outputs 1ns later, then advance the model.
    task automatic step();
        bit          rv, rdr_eff, exp_rv, exp_iv, deq;
        logic [31:0] rd;
        int          unf, fil, due;
        @(negedge clock);
        reset = 1'b0;
        rv    = 1'b0;
        rd    = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            rv = 1'b1;
            rd = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end
        rdr_eff = rdr || (arm_resp && rv);
        if (arm_resp && rv) fired = 1'b1;
        imem_resp_valid = rv;
        imem_resp_data  = rd;
        imem_req_ready  = rdy;
        stall           = stl;
        redirect        = rdr_eff;
        redirect_pc     = rpc;
        #1;
        fil = 0;
        unf = 0;
        foreach (mq[i]) begin
            if (mq[i].filled) fil++;
            else unf++;
        end
        exp_rv = !rdr_eff && (mq.size() + m_disc < DEPTH);
        check("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) check("req_addr", imem_req_addr, m_fetch_pc);
        exp_iv = mq.size() > 0 && mq[0].filled && !rdr_eff;
        check("if_valid", if_valid, exp_iv);
        if (exp_iv) begin
            check("if_pc", if_pc, mq[0].pc);
            check("pc_stream", if_pc, next_pc);
            check("if_instr", if_instruction, mq[0].instr);
        end
        if (if_valid && first_iv < 0) first_iv = since_reset;
        // Filled slots plus requests still owed by memory may never exceed the queue.
        check("invariant", 64'(pend.size() + int'(rv) + fil <= DEPTH), 64'd1);
`ifdef FETCH_PERF_EN
        check("perf_fetched", perf_fetched, 64'(m_fetched));
        check("perf_dropped", perf_dropped, 64'(m_dropped));
`endif
        deq = exp_iv && !stl;
        if (imem_req_valid && rdy) begin
            acc_cnt++;
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{imem_req_addr, due});
        end
        if (rdr_eff) begin
            m_dropped += fil + int'(rv);
            m_disc     = m_disc + unf - int'(rv);
            mq.delete();
            m_fetch_pc = rpc;
            next_pc    = rpc;
        end else begin
            if (rv) begin
                if (m_disc > 0) begin
                    m_disc--;
                    m_dropped++;
                end else begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!mq[i].filled) begin
                            mq[i].filled = 1'b1;
                            mq[i].instr  = rd;
                            break;
                        end
                    end
                end
            end
            if (deq) begin
                next_pc = mq[0].pc + 64'd4;
                void'(mq.pop_front());
                m_fetched++;
            end
            if (exp_rv && rdy) begin
                mq.push_back('{m_fetch_pc, 32'h0, 1'b0});
                m_fetch_pc = m_fetch_pc + 64'd4;
            end
        end
        cyc++;
        since_reset++;
    endtask

    initial begin
        int expect_acc;

        // Reset and sequential fetch with a 1-cycle memory.
        do_reset();
        lat_lo = 1; lat_hi = 1; rdy = 1'b1; stl = 1'b0; rdr = 1'b0;
        repeat (20) step();
        check("first_if_valid_cycle", 64'(first_iv), 64'd2);

        // Stall: queue fills, issue stops, head holds.
        expect_acc = DEPTH - mq.size() - m_disc;
        acc_cnt    = 0;
        stl        = 1'b1;
        repeat (10) step();
        check("stall_accepts", 64'(acc_cnt), 64'(expect_acc));
        stl = 1'b0;
        repeat (8) step();

        // 3-cycle memory, redirect with requests in flight.
        lat_lo = 3; lat_hi = 3;
        repeat (8) step();
        rdr = 1'b1; rpc = 64'h100;
        step();
        rdr = 1'b0;
        repeat (15) step();

        // Redirect near the top of the address space: fetch PC wraps to zero.
        rdr = 1'b1; rpc = 64'hFFFF_FFFF_FFFF_FFF8;
        step();
        rdr = 1'b0;
        repeat (15) step();

        // Redirect on a response cycle followed by a second redirect to 0x200.
        lat_lo = 2; lat_hi = 3;
        rpc = 64'h180; fired = 1'b0; arm_resp = 1'b1;
        for (int i = 0; i < 20 && !fired; i++) step();
        arm_resp = 1'b0;
        check("redirect_on_resp_seen", 64'(fired), 64'd1);
        rdr = 1'b1; rpc = 64'h200;
        step();
        rdr = 1'b0;
        repeat (20) step();

        // Random ready, latency, stall and occasional redirects.
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 1000; i++) begin
            rdy = 1'($urandom_range(1, 0));
            stl = ($urandom_range(3, 0) == 0);
            rdr = ($urandom_range(49, 0) == 0);
            rpc = {$urandom(), $urandom()} & 64'hFFFF_FFFF_FFFF_FFFC;
            step();
        end
        rdr = 1'b0; stl = 1'b0; rdy = 1'b1;
        repeat (10) step();

        // Fill the queue under stall, then reset mid-burst.
        lat_lo = 1; lat_hi = 1; stl = 1'b1;
        repeat (8) step();
        check("full_before_reset", 64'(mq.size()), 64'(DEPTH));
        do_reset();
        stl = 1'b0;
        repeat (12) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
